// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN         : architectural register / address width
//   NOP_INSTR    : canonical bubble (addi x0, x0, 0)
//   fetch_slot_t : one fetch-queue entry {pc, instr, full}
//                  full=0 -> ALLOC (request accepted, data pending)
//                  full=1 -> FULL  (instruction word present)
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            full;
    } fetch_slot_t;

    // Sequential PC step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer between the imem interface and the IF/ID register.
// Slots are allocated in request order, filled in response order and
// popped in program order, so three independent pointers walk the ring.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   clear        : drop every slot (FULL and ALLOC) this cycle
//   alloc        : allocate a slot tagged with alloc_pc
//   fill         : write fill_instr into the oldest ALLOC slot
//   pop          : retire the head slot (caller guarantees head_full)
//   head         : head slot contents
//   head_full    : queue non-empty and head slot holds data
//   alloc_cnt    : number of ALLOC slots (awaiting a response)
//   used         : number of occupied slots (ALLOC + FULL)
module fetch_queue
    import riscv_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_instr,
    input  logic            pop,
    output fetch_slot_t     head,
    output logic            head_full,
    output logic [CW-1:0]   alloc_cnt,
    output logic [CW-1:0]   used
);

    fetch_slot_t   slots_q [DEPTH];
    fetch_slot_t   slots_d [DEPTH];
    logic [PW-1:0] head_ptr_q,  head_ptr_d;
    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
    logic [CW-1:0] used_q,      used_d;
    logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;

    always_comb begin
        slots_d     = slots_q;
        head_ptr_d  = head_ptr_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        used_d      = used_q;
        alloc_cnt_d = alloc_cnt_q;

        if (clear) begin
            // Stale slot contents are left in place; used==0 masks them and
            // every later allocation rewrites the full bit.
            head_ptr_d  = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            used_d      = '0;
            alloc_cnt_d = '0;
        end else begin
            // Power-of-two DEPTH: pointer increments wrap at DEPTH naturally.
            if (alloc) begin
                slots_d[alloc_ptr_q].pc    = alloc_pc;
                slots_d[alloc_ptr_q].instr = NOP_INSTR;
                slots_d[alloc_ptr_q].full  = 1'b0;
                alloc_ptr_d                = alloc_ptr_q + PW'(1);
            end
            // A fill always targets an older slot than this cycle's alloc,
            // because responses arrive at least one cycle after acceptance.
            if (fill) begin
                slots_d[fill_ptr_q].instr = fill_instr;
                slots_d[fill_ptr_q].full  = 1'b1;
                fill_ptr_d                = fill_ptr_q + PW'(1);
            end
            if (pop) begin
                head_ptr_d = head_ptr_q + PW'(1);
            end
            used_d      = used_q + CW'(alloc) - CW'(pop);
            alloc_cnt_d = alloc_cnt_q + CW'(alloc) - CW'(fill);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr_q  <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            used_q      <= '0;
            alloc_cnt_q <= '0;
        end else begin
            head_ptr_q  <= head_ptr_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            used_q      <= used_d;
            alloc_cnt_q <= alloc_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slots_q[i] <= slots_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            assert (!(alloc && (used_q == CW'(DEPTH))))
                else $error("fetch_queue: alloc into full queue");
            assert (!(pop && !head_full))
                else $error("fetch_queue: pop without a FULL head");
            assert (!(fill && (alloc_cnt_q == '0)))
                else $error("fetch_queue: fill with no ALLOC slot");
        end
    end

    assign head      = slots_q[head_ptr_q];
    assign head_full = (used_q != '0) && slots_q[head_ptr_q].full;
    assign alloc_cnt = alloc_cnt_q;
    assign used      = used_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns PCF, issues in-order imem requests, buffers returned words
// in fetch_queue and loads the IF/ID register for decode.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   StallF          : suppress new imem requests
//   StallD          : hold IF/ID, do not pop the queue
//   FlushD          : load a NOP bubble into IF/ID
//   PCSrcE/PCTargetE: EX-stage redirect and its target
//   ImemReq*        : request channel (valid/ready), ImemAddr = PCF
//   ImemRsp*        : in-order response channel
//   InstrD/PCD/PCPlus4D/InstrValidD : IF/ID register
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        InstrValidD
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pcf_q,         pcf_d;
    logic [CW-1:0]   drop_cnt_q,    drop_cnt_d;
    logic [XLEN-1:0] instr_q,       instr_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic [XLEN-1:0] pc_plus4_q,    pc_plus4_d;
    logic            instr_valid_q, instr_valid_d;

    logic            accept;
    logic            fill;
    logic            pop;
    fetch_slot_t     head;
    logic            head_full;
    logic [CW-1:0]   alloc_cnt;
    logic [CW-1:0]   used;

    // Responses still owed for slots discarded by a redirect count against
    // the queue budget, so the imem never holds more than DEPTH in flight.
    assign ImemReqValid = !reset && !StallF && !PCSrcE &&
                          (({1'b0, used} + {1'b0, drop_cnt_q}) < DEPTH_W);
    assign accept       = ImemReqValid && ImemReqReady;
    assign ImemAddr     = pcf_q;

    assign fill = !reset && !PCSrcE && ImemRspValid && (drop_cnt_q == '0);

    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = PCTargetE;
        end else if (accept) begin
            pcf_d = pc_plus4(pcf_q);
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (PCSrcE) begin
            // Every ALLOC slot becomes an orphan response; one arriving this
            // same cycle is already accounted for.
            drop_cnt_d = drop_cnt_q + alloc_cnt - CW'(ImemRspValid);
        end else if (ImemRspValid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_comb begin
        instr_d       = instr_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        instr_valid_d = instr_valid_q;
        pop           = 1'b0;

        if (FlushD || PCSrcE) begin
            instr_d       = NOP_INSTR;
            pc_d          = '0;
            pc_plus4_d    = '0;
            instr_valid_d = 1'b0;
        end else if (!StallD) begin
            if (head_full) begin
                pop           = !reset;
                instr_d       = head.instr;
                pc_d          = head.pc;
                pc_plus4_d    = pc_plus4(head.pc);
                instr_valid_d = 1'b1;
            end else begin
                instr_d       = NOP_INSTR;
                pc_d          = '0;
                pc_plus4_d    = '0;
                instr_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q         <= RESET_PC;
            drop_cnt_q    <= '0;
            instr_q       <= NOP_INSTR;
            pc_q          <= '0;
            pc_plus4_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pcf_q         <= pcf_d;
            drop_cnt_q    <= drop_cnt_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .clear      (PCSrcE),
        .alloc      (accept),
        .alloc_pc   (pcf_q),
        .fill       (fill),
        .fill_instr (ImemRspData),
        .pop        (pop),
        .head       (head),
        .head_full  (head_full),
        .alloc_cnt  (alloc_cnt),
        .used       (used)
    );

    // A response that matches no ALLOC slot and no pending drop means the
    // imem broke the in-order, one-response-per-request contract.
    always_ff @(posedge clk) begin
        if (!reset && ImemRspValid && (drop_cnt_q == '0)) begin
            assert (alloc_cnt != '0)
                else $error("instruction_fetch: unexpected imem response");
        end
    end

    assign InstrD      = instr_q;
    assign PCD         = pc_q;
    assign PCPlus4D    = pc_plus4_q;
    assign InstrValidD = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        ImemReqValid, ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        InstrValidD;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus4D     (PCPlus4D),
        .InstrValidD  (InstrValidD)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Instruction memory model: in-order queue of accepted addresses.
    logic [31:0] q_addr [$];
    int          q_due  [$];
    int          cyc     = 0;
    bit          g_ready = 1'b1;
    bit          g_rand  = 1'b0;
    int          g_lat   = 1;

    // Observations of the current cycle.
    logic        s_reqv, s_acc, s_ivd;
    logic [31:0] s_addr, s_pcd, s_instr, s_p4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt);
        logic rdy;
        @(negedge clk);
        rdy = g_rand ? ($urandom_range(0, 9) < 7) : g_ready;
        reset = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
        ImemReqReady = rdy;
        if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            ImemRspValid = 1'b1;
            ImemRspData  = q_addr[0] ^ KEY;
        end else begin
            ImemRspValid = 1'b0;
            ImemRspData  = $urandom;
        end
        #1;
        s_reqv  = ImemReqValid;
        s_addr  = ImemAddr;
        s_acc   = ImemReqValid && rdy;
        s_ivd   = InstrValidD;
        s_pcd   = PCD;
        s_instr = InstrD;
        s_p4    = PCPlus4D;
        @(posedge clk);
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (ImemRspValid) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (s_acc) begin
                q_addr.push_back(s_addr);
                q_due.push_back(cyc + (g_rand ? int'($urandom_range(1, 4)) : g_lat));
            end
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic chk_instr(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, {31'b0, s_ivd}, 32'd1);
        chk({name, "_pcd"}, s_pcd, pc);
        chk({name, "_instr"}, s_instr, pc ^ KEY);
        chk({name, "_pc4"}, s_p4, pc + 32'd4);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, {31'b0, s_ivd}, 32'd0);
        chk({name, "_instr"}, s_instr, NOP);
        chk({name, "_pcd"}, s_pcd, 32'h0);
        chk({name, "_pc4"}, s_p4, 32'h0);
    endtask

    // Advance idle cycles until decode receives an instruction; it must be pc.
    task automatic wait_valid(input string name, input logic [31:0] pc, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            idle();
            if (s_ivd) got = 1'b1;
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
        else      chk_instr(name, pc);
    endtask

    typedef struct {
        bit          rst, sd, fd;
        bit          exp_reqv;
        logic [31:0] exp_addr;
        bit          chk_out;
        bit          exp_ivd;
        logic [31:0] exp_pc;
        bit          zero_chk;
    } vec_t;

    function automatic vec_t mk(bit rst, bit sd, bit fd, bit reqv, logic [31:0] addr,
                                bit co, bit ivd, logic [31:0] pc, bit z);
        vec_t v;
        v.rst = rst; v.sd = sd; v.fd = fd; v.exp_reqv = reqv; v.exp_addr = addr;
        v.chk_out = co; v.exp_ivd = ivd; v.exp_pc = pc; v.zero_chk = z;
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        logic [31:0] exp_fetch, exp_stream, tgt;
        logic        sf, sd, fd, ps, prev_hold;
        logic        p_ivd;
        logic [31:0] p_pcd, p_instr, p_p4;
        int unsigned n_instr;

        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; ImemReqReady = 1'b1; ImemRspValid = 1'b0; ImemRspData = '0;

        // Startup stream, StallD hold with full queue, lone FlushD.
        //            rst sd fd reqv addr   co ivd pc     zero
        tbl[0]  = mk(1, 0, 0, 0, 32'd0,  0, 0, 32'd0,  0);
        tbl[1]  = mk(0, 0, 0, 1, 32'd0,  1, 0, 32'd0,  1);
        tbl[2]  = mk(0, 0, 0, 1, 32'd4,  1, 0, 32'd0,  0);
        tbl[3]  = mk(0, 0, 0, 1, 32'd8,  1, 0, 32'd0,  0);
        tbl[4]  = mk(0, 0, 0, 1, 32'd12, 1, 1, 32'd0,  0);
        tbl[5]  = mk(0, 0, 0, 1, 32'd16, 1, 1, 32'd4,  0);
        tbl[6]  = mk(0, 1, 0, 1, 32'd20, 1, 1, 32'd8,  0);
        tbl[7]  = mk(0, 1, 0, 1, 32'd24, 1, 1, 32'd8,  0);
        tbl[8]  = mk(0, 1, 0, 0, 32'd28, 1, 1, 32'd8,  0);
        tbl[9]  = mk(0, 0, 0, 0, 32'd28, 1, 1, 32'd8,  0);
        tbl[10] = mk(0, 0, 0, 1, 32'd28, 1, 1, 32'd12, 0);
        tbl[11] = mk(0, 0, 0, 1, 32'd32, 1, 1, 32'd16, 0);
        tbl[12] = mk(0, 0, 0, 1, 32'd36, 1, 1, 32'd20, 0);
        tbl[13] = mk(0, 0, 0, 1, 32'd40, 1, 1, 32'd24, 0);
        tbl[14] = mk(0, 0, 1, 1, 32'd44, 1, 1, 32'd28, 0);
        tbl[15] = mk(0, 0, 0, 0, 32'd48, 1, 0, 32'd0,  1);
        tbl[16] = mk(0, 0, 0, 1, 32'd48, 1, 1, 32'd32, 0);
        tbl[17] = mk(0, 0, 0, 1, 32'd52, 1, 1, 32'd36, 0);
        tbl[18] = mk(0, 0, 0, 1, 32'd56, 1, 1, 32'd40, 0);

        g_lat = 1; g_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, 1'b0, tbl[i].sd, tbl[i].fd, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_reqv", i), {31'b0, s_reqv}, {31'b0, tbl[i].exp_reqv});
            if (!tbl[i].rst) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].exp_addr);
            if (tbl[i].chk_out) begin
                if (tbl[i].zero_chk)     chk_zero($sformatf("tbl%0d", i));
                else if (tbl[i].exp_ivd) chk_instr($sformatf("tbl%0d", i), tbl[i].exp_pc);
                else begin
                    chk($sformatf("tbl%0d_valid", i), {31'b0, s_ivd}, 32'd0);
                    chk($sformatf("tbl%0d_instr", i), s_instr, NOP);
                end
            end
        end

        // Redirect with 2 ALLOC + 1 FULL slots (3-cycle imem).
        g_lat = 3;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 6; i++) begin
            idle();
            if (i == 5) chk("redir_full_noreq", {31'b0, s_reqv}, 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        chk("redir_noreq", {31'b0, s_reqv}, 32'd0);
        idle();
        chk("redir_req", {31'b0, s_reqv}, 32'd1);
        chk("redir_addr", s_addr, 32'h0000_0100);
        chk("redir_bubble", {31'b0, s_ivd}, 32'd0);
        wait_valid("redir_first", 32'h0000_0100, 12);
        wait_valid("redir_second", 32'h0000_0104, 8);

        // Imem not ready for 5 cycles.
        g_lat = 1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        g_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk($sformatf("nrdy%0d_valid", i), {31'b0, s_reqv}, 32'd1);
            chk($sformatf("nrdy%0d_addr", i), s_addr, 32'h0);
        end
        g_ready = 1'b1;
        wait_valid("nrdy_first", 32'd0, 10);
        wait_valid("nrdy_second", 32'd4, 4);
        wait_valid("nrdy_third", 32'd8, 4);

        // Reset with three requests in flight.
        g_lat = 3;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        chk_zero("rst_mid");
        chk("rst_mid_req", {31'b0, s_reqv}, 32'd1);
        chk("rst_mid_addr", s_addr, 32'h0);
        wait_valid("rst_first", 32'd0, 12);
        wait_valid("rst_second", 32'd4, 8);

        // Redirect to the top of the address space: PC wraps to 0.
        g_lat = 1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid("wrap_top", 32'hFFFF_FFFC, 10);
        wait_valid("wrap_zero", 32'h0, 4);
        wait_valid("wrap_four", 32'h4, 4);

        // Random traffic against a program-order model: every instruction
        // delivered to decode follows its predecessor by +4 unless a redirect
        // intervened, and every accepted address follows the same rule.
        g_rand = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_fetch = 32'h0; exp_stream = 32'h0; prev_hold = 1'b0; n_instr = 0;
        p_ivd = 1'b0; p_pcd = '0; p_instr = '0; p_p4 = '0;
        for (int i = 0; i < 3000; i++) begin
            sf = ($urandom_range(0, 9) == 0);
            sd = ($urandom_range(0, 6) == 0);
            fd = ($urandom_range(0, 19) == 0);
            ps = ($urandom_range(0, 31) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            step(1'b0, sf, sd, fd, ps, tgt);
            if (sf || ps) chk("rnd_req_blocked", {31'b0, s_reqv}, 32'd0);
            if (s_acc) begin
                chk("rnd_fetch_addr", s_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (prev_hold) begin
                chk("rnd_hold_valid", {31'b0, s_ivd}, {31'b0, p_ivd});
                chk("rnd_hold_pcd", s_pcd, p_pcd);
                chk("rnd_hold_instr", s_instr, p_instr);
                chk("rnd_hold_pc4", s_p4, p_p4);
            end else if (s_ivd) begin
                chk_instr("rnd_stream", exp_stream);
                exp_stream = exp_stream + 32'd4;
                n_instr++;
            end else begin
                chk("rnd_bubble_instr", s_instr, NOP);
            end
            p_ivd = s_ivd; p_pcd = s_pcd; p_instr = s_instr; p_p4 = s_p4;
            prev_hold = sd && !fd && !ps;
            if (ps) begin
                exp_fetch  = tgt;
                exp_stream = tgt;
            end
        end
        chk("rnd_progress", {31'b0, (n_instr >= 300)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
